// File: rtl/z80_bus_ctrl_if.sv
// z80_bus_ctrl_if: CPU, memory and SIO signals around the fz80 bus controller
interface z80_bus_ctrl_if #(
    parameter int ROM_AW = 14,
    parameter int RAM_AW = 12
);
    logic              cpu_mreq;
    logic              cpu_iorq;
    logic              cpu_rd;
    logic              cpu_wr;
    logic [15:0]       cpu_addr;
    logic [7:0]        cpu_dout;
    logic [7:0]        cpu_din;
    logic              cpu_wait;
    logic [7:0]        bus_wdata;
    logic [ROM_AW-1:0] rom_addr;
    logic [7:0]        rom_q;
    logic [RAM_AW-1:0] ram_addr;
    logic              ram_we;
    logic [7:0]        ram_q;
    logic              sio_ce;
    logic              sio_cd;
    logic              sio_rd;
    logic              sio_wr;
    logic [7:0]        sio_rdata;
    logic              sio_ack;
    logic              bus_err;

    modport master (
        input  cpu_mreq, cpu_iorq, cpu_rd, cpu_wr, cpu_addr, cpu_dout,
        input  rom_q, ram_q, sio_rdata, sio_ack,
        output cpu_din, cpu_wait, bus_wdata, rom_addr, ram_addr, ram_we,
        output sio_ce, sio_cd, sio_rd, sio_wr, bus_err
    );

    modport slave (
        output cpu_mreq, cpu_iorq, cpu_rd, cpu_wr, cpu_addr, cpu_dout,
        output rom_q, ram_q, sio_rdata, sio_ack,
        input  cpu_din, cpu_wait, bus_wdata, rom_addr, ram_addr, ram_we,
        input  sio_ce, sio_cd, sio_rd, sio_wr, bus_err
    );
endinterface

// File: rtl/z80_bus_ctrl.sv
// z80_bus_ctrl: sequences fz80 mreq/iorq cycles onto ROM, RAM and SIO, holding cpu_wait until each access completes
module z80_bus_ctrl #(
    parameter int          ROM_AW     = 14,
    parameter logic [15:0] RAM_BASE   = 16'h8000,
    parameter int          RAM_AW     = 12,
    parameter logic [7:0]  SIO_BASE   = 8'h84,
    parameter int          ROM_WAIT   = 2,
    parameter int          RAM_WAIT   = 1,
    parameter int          IO_TIMEOUT = 64
) (
    input  logic           cpu_clk,
    input  logic           n_RST,
    z80_bus_ctrl_if.master bus
);
    localparam int CW = $clog2(ROM_WAIT > RAM_WAIT ? ROM_WAIT : RAM_WAIT) + 1;
    localparam int TW = $clog2(IO_TIMEOUT);

    typedef enum logic [2:0] {IDLE, MEM_WAIT, SIO_REQ, SIO_WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic [ROM_AW-1:0] rom_a_q, rom_a_d;
    logic [RAM_AW-1:0] ram_a_q, ram_a_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        din_q, din_d;
    logic              cd_q, cd_d;
    logic              wr_q, wr_d;
    logic              rom_sel_q, rom_sel_d;
    logic              err_q, err_d;
    logic [2:0]        ack_q;

    logic req, rom_hit, ram_hit, sio_hit, stall, accept, timeout, mem_last, sio_act;

    assign req      = (bus.cpu_mreq ^ bus.cpu_iorq) & (bus.cpu_rd ^ bus.cpu_wr);
    assign rom_hit  = bus.cpu_mreq & (bus.cpu_addr[15:ROM_AW] == '0);
    assign ram_hit  = bus.cpu_mreq & (bus.cpu_addr[15:RAM_AW] == RAM_BASE[15:RAM_AW]);
    assign sio_hit  = bus.cpu_iorq & (bus.cpu_addr[7:1] == SIO_BASE[7:1]);
    // ROM writes and unmapped cycles complete immediately, so they never stall
    assign stall    = (rom_hit & ~bus.cpu_wr) | ram_hit | sio_hit;
    assign accept   = ack_q[1] & ~ack_q[2];
    assign timeout  = tmr_q == TW'(IO_TIMEOUT - 1);
    assign mem_last = state_q == MEM_WAIT && cnt_q == '0;
    assign sio_act  = state_q inside {SIO_REQ, SIO_WAIT};

    assign bus.cpu_wait  = (state_q == IDLE && req && stall) || state_q inside {MEM_WAIT, SIO_REQ, SIO_WAIT};
    assign bus.cpu_din   = din_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.rom_addr  = rom_a_q;
    assign bus.ram_addr  = ram_a_q;
    assign bus.ram_we    = mem_last & wr_q;
    assign bus.sio_ce    = sio_act;
    assign bus.sio_cd    = cd_q;
    assign bus.sio_rd    = sio_act & ~wr_q;
    assign bus.sio_wr    = sio_act & wr_q;
    assign bus.bus_err   = err_q;

    always_ff @(posedge cpu_clk or negedge n_RST) begin
        if (!n_RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tmr_q     <= '0;
            rom_a_q   <= '0;
            ram_a_q   <= '0;
            wdata_q   <= '0;
            din_q     <= 8'hFF;
            cd_q      <= 1'b0;
            wr_q      <= 1'b0;
            rom_sel_q <= 1'b0;
            err_q     <= 1'b0;
            ack_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmr_q     <= tmr_d;
            rom_a_q   <= rom_a_d;
            ram_a_q   <= ram_a_d;
            wdata_q   <= wdata_d;
            din_q     <= din_d;
            cd_q      <= cd_d;
            wr_q      <= wr_d;
            rom_sel_q <= rom_sel_d;
            err_q     <= err_d;
            ack_q     <= {ack_q[1:0], bus.sio_ack};
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmr_d     = tmr_q;
        rom_a_d   = rom_a_q;
        ram_a_d   = ram_a_q;
        wdata_d   = wdata_q;
        din_d     = din_q;
        cd_d      = cd_q;
        wr_d      = wr_q;
        rom_sel_d = rom_sel_q;
        err_d     = err_q;
        case (state_q)
            IDLE: if (req) begin
                rom_a_d   = bus.cpu_addr[ROM_AW-1:0];
                ram_a_d   = bus.cpu_addr[RAM_AW-1:0];
                cd_d      = bus.cpu_addr[0];
                wr_d      = bus.cpu_wr;
                wdata_d   = bus.cpu_dout;
                rom_sel_d = rom_hit;
                cnt_d     = rom_hit ? CW'(ROM_WAIT - 1) : CW'(RAM_WAIT - 1);
                err_d     = err_q | (rom_hit & bus.cpu_wr);
                din_d     = (!stall && bus.cpu_rd) ? 8'hFF : din_q;
                state_d   = !stall ? DONE : sio_hit ? SIO_REQ : MEM_WAIT;
            end
            MEM_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (mem_last) begin
                    din_d   = wr_q ? din_q : rom_sel_q ? bus.rom_q : bus.ram_q;
                    state_d = DONE;
                end
            end
            SIO_REQ: begin
                tmr_d   = '0;
                state_d = SIO_WAIT;
            end
            SIO_WAIT: begin
                tmr_d = tmr_q + TW'(1);
                if (accept || timeout) begin
                    din_d   = wr_q ? din_q : accept ? bus.sio_rdata : 8'hFF;
                    err_d   = err_q | ~accept;
                    state_d = DONE;
                end
            end
            DONE: if (!bus.cpu_rd && !bus.cpu_wr) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule
